// File: rtl/jtag_tap_gen_if.sv
// Pin-level bundle of the JTAG TAP: serial pins, state readback and the
// boundary-scan / USER register parallel ports. TCK and TRST stay outside.
interface jtag_tap_gen_if #(
    parameter int BSR_LEN    = 14,
    parameter int USER_WIDTH = 8
);
    logic                  TMS;
    logic                  TDI;
    logic                  TDO;
    logic                  tdo_en;
    logic [3:0]            tap_state;
    logic [BSR_LEN-1:0]    bsr_capture_in;
    logic [BSR_LEN-1:0]    bsr_update_out;
    logic                  bsr_mode;
    logic [USER_WIDTH-1:0] user_capture_in;
    logic [USER_WIDTH-1:0] user_update_out;
    logic                  user_update_stb;

    modport master (
        output TMS, TDI, bsr_capture_in, user_capture_in,
        input  TDO, tdo_en, tap_state, bsr_update_out, bsr_mode,
               user_update_out, user_update_stb
    );

    modport slave (
        input  TMS, TDI, bsr_capture_in, user_capture_in,
        output TDO, tdo_en, tap_state, bsr_update_out, bsr_mode,
               user_update_out, user_update_stb
    );
endinterface

// File: rtl/jtag_tap_gen.sv
// IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE, boundary-scan and USER
// data registers. Define JTAG_USER_REG_EN to build the USER register.
module jtag_tap_gen #(
    parameter int          IR_WIDTH   = 4,
    parameter int          BSR_LEN    = 14,
    parameter int          USER_WIDTH = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input logic           TCK,
    input logic           TRST,
    jtag_tap_gen_if.slave jtag
);
    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0, EXIT1_DR   = 4'h1, SHIFT_DR   = 4'h2, PAUSE_DR  = 4'h3,
        SELECT_IR  = 4'h4, UPDATE_DR  = 4'h5, CAPTURE_DR = 4'h6, SELECT_DR = 4'h7,
        EXIT2_IR   = 4'h8, EXIT1_IR   = 4'h9, SHIFT_IR   = 4'hA, PAUSE_IR  = 4'hB,
        RUN_IDLE   = 4'hC, UPDATE_IR  = 4'hD, CAPTURE_IR = 4'hE, TEST_RESET = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BSR, SEL_IDCODE, SEL_USER, SEL_BYPASS} dr_sel_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(2);
    localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(8);

    tap_state_e            state_q, state_d;
    dr_sel_e               dr_sel;
    logic [IR_WIDTH-1:0]   ir_sh_q, ir_q;
    logic [BSR_LEN-1:0]    bsr_sh_q, bsr_upd_q;
    logic [31:0]           id_sh_q;
    logic                  byp_q;
    logic                  tms, tdi, tdo;
    logic                  enter_tlr, capture_dr, shift_dr, update_dr, shift_ir;

    assign tms = jtag.TMS;
    assign tdi = jtag.TDI;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state_q <= TEST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TEST_RESET: state_d = tms ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   state_d = tms ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  state_d = tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: state_d = tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   state_d = tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   state_d = tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   state_d = tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   state_d = tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  state_d = tms ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  state_d = tms ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: state_d = tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   state_d = tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   state_d = tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   state_d = tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   state_d = tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  state_d = tms ? SELECT_DR  : RUN_IDLE;
            default:    state_d = TEST_RESET;
        endcase
    end

    // The edge that leaves a Shift state (TMS=1) does not shift.
    assign enter_tlr  = (state_d == TEST_RESET);
    assign capture_dr = (state_q == CAPTURE_DR);
    assign shift_dr   = (state_q == SHIFT_DR) && !tms;
    assign update_dr  = (state_q == UPDATE_DR);
    assign shift_ir   = (state_q == SHIFT_IR) && !tms;

    always_comb begin
        dr_sel = SEL_BYPASS;
        if (ir_q == OP_EXTEST || ir_q == OP_SAMPLE) dr_sel = SEL_BSR;
        else if (ir_q == OP_IDCODE)                 dr_sel = SEL_IDCODE;
`ifdef JTAG_USER_REG_EN
        else if (ir_q == OP_USER)                   dr_sel = SEL_USER;
`endif
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sh_q <= '0;
            ir_q    <= OP_IDCODE;
        end else if (enter_tlr) begin
            ir_sh_q <= '0;
            ir_q    <= OP_IDCODE;
        end else begin
            if (state_q == CAPTURE_IR) ir_sh_q <= IR_WIDTH'(1);
            else if (shift_ir)         ir_sh_q <= {tdi, ir_sh_q[IR_WIDTH-1:1]};
            if (state_q == UPDATE_IR)  ir_q    <= ir_sh_q;
        end
    end

    // Update latches survive a TMS-driven reset; only TRST clears them.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            bsr_sh_q  <= '0;
            bsr_upd_q <= '0;
            id_sh_q   <= '0;
            byp_q     <= 1'b0;
        end else if (enter_tlr) begin
            bsr_sh_q <= '0;
            id_sh_q  <= '0;
            byp_q    <= 1'b0;
        end else begin
            if (dr_sel == SEL_BSR) begin
                if (capture_dr)    bsr_sh_q  <= jtag.bsr_capture_in;
                else if (shift_dr) bsr_sh_q  <= {tdi, bsr_sh_q[BSR_LEN-1:1]};
                if (update_dr)     bsr_upd_q <= bsr_sh_q;
            end
            if (dr_sel == SEL_IDCODE) begin
                if (capture_dr)    id_sh_q <= {IDCODE_VAL[31:1], 1'b1};
                else if (shift_dr) id_sh_q <= {tdi, id_sh_q[31:1]};
            end
            if (dr_sel == SEL_BYPASS) begin
                if (capture_dr)    byp_q <= 1'b0;
                else if (shift_dr) byp_q <= tdi;
            end
        end
    end

`ifdef JTAG_USER_REG_EN
    logic [USER_WIDTH-1:0] user_sh_q, user_upd_q;
    logic                  user_stb_q;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            user_sh_q  <= '0;
            user_upd_q <= '0;
            user_stb_q <= 1'b0;
        end else if (enter_tlr) begin
            user_sh_q  <= '0;
            user_stb_q <= 1'b0;
        end else begin
            user_stb_q <= update_dr && (dr_sel == SEL_USER);
            if (dr_sel == SEL_USER) begin
                if (capture_dr)    user_sh_q  <= jtag.user_capture_in;
                else if (shift_dr) user_sh_q  <= {tdi, user_sh_q[USER_WIDTH-1:1]};
                if (update_dr)     user_upd_q <= user_sh_q;
            end
        end
    end

    assign jtag.user_update_out = user_upd_q;
    assign jtag.user_update_stb = user_stb_q;
`else
    logic unused_user;
    assign unused_user          = ^jtag.user_capture_in;
    assign jtag.user_update_out = '0;
    assign jtag.user_update_stb = 1'b0;
`endif

    always_comb begin
        tdo = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo = ir_sh_q[0];
        end else if (state_q == SHIFT_DR) begin
            case (dr_sel)
                SEL_BSR:    tdo = bsr_sh_q[0];
                SEL_IDCODE: tdo = id_sh_q[0];
`ifdef JTAG_USER_REG_EN
                SEL_USER:   tdo = user_sh_q[0];
`endif
                SEL_BYPASS: tdo = byp_q;
                default:    tdo = 1'b0;
            endcase
        end
    end

    assign jtag.TDO            = tdo;
    assign jtag.tdo_en         = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
    assign jtag.tap_state      = state_q;
    assign jtag.bsr_update_out = bsr_upd_q;
    assign jtag.bsr_mode       = (ir_q == OP_EXTEST);
endmodule

// File: tb/tb_jtag_tap_gen.sv
// Scoreboard bench for jtag_tap_gen: scan tasks push expected TDO bits, a
// negedge monitor pops them whenever tdo_en is high.
module tb_jtag_tap_gen;
    localparam int IRW  = 4;
    localparam int BSRL = 14;
    localparam int UW   = 8;
`ifdef JTAG_USER_REG_EN
    localparam bit USER_EN = 1'b1;
`else
    localparam bit USER_EN = 1'b0;
`endif

    logic TCK  = 1'b0;
    logic TRST = 1'b1;

    jtag_tap_gen_if #(.BSR_LEN(BSRL), .USER_WIDTH(UW)) jtag ();

    jtag_tap_gen #(
        .IR_WIDTH(IRW), .BSR_LEN(BSRL), .USER_WIDTH(UW), .IDCODE_VAL(32'h1000_0001)
    ) dut (
        .TCK(TCK), .TRST(TRST), .jtag(jtag)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit ignore_tdo = 1'b0;
    bit walk = 1'b0;

    // TAP graph as two lookup tables indexed by state code (TMS=0 / TMS=1).
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];

    logic [3:0]      m_state;
    logic [IRW-1:0]  m_ir;
    logic [BSRL-1:0] m_bsr_upd;
    logic [UW-1:0]   m_user_upd;
    bit              m_stb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // 0 = BSR, 1 = IDCODE, 2 = USER, 3 = BYPASS
    function automatic int dr_kind(input logic [IRW-1:0] ir);
        if (ir == 0 || ir == 2) return 0;
        if (ir == 1) return 1;
        if (USER_EN && ir == IRW'(8)) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_state    = 4'hF;
        m_ir       = IRW'(1);
        m_bsr_upd  = '0;
        m_user_upd = '0;
        m_stb      = 1'b0;
    endtask

    task automatic tick(input bit tms, input bit tdi);
        logic [3:0] prev;
        jtag.TMS = tms;
        jtag.TDI = tdi;
        @(posedge TCK);
        #1;
        prev    = m_state;
        m_state = tms ? nxt1[prev] : nxt0[prev];
        m_stb   = (prev == 4'h5) && (dr_kind(m_ir) == 2);
        if (m_state == 4'hF) m_ir = IRW'(1);
        check("tap_state", 64'(jtag.tap_state), 64'(m_state));
        if (!walk) begin
            check("bsr_mode", 64'(jtag.bsr_mode), 64'(m_ir == 0));
            check("bsr_update_out", 64'(jtag.bsr_update_out), 64'(m_bsr_upd));
            check("user_update_out", 64'(jtag.user_update_out), 64'(m_user_upd));
            check("user_update_stb", 64'(jtag.user_update_stb), 64'(m_stb));
        end
    endtask

    task automatic ir_scan(input logic [IRW-1:0] val);
        logic [2*IRW-1:0] stream;
        stream = {val, IRW'(1)};
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < IRW; i++) begin
            exp_q.push_back(stream[i]);
            tick(0, val[i]);
        end
        exp_q.push_back(stream[IRW]);
        tick(1, 0);
        tick(1, 0);
        m_ir = val;
        tick(0, 0);
        $display("IR scan: opcode 0x%0h", val);
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din);
        int           kind, len;
        logic [63:0]  cap, upd;
        logic [127:0] stream;
        kind = dr_kind(m_ir);
        case (kind)
            0:       begin len = BSRL; cap = 64'(jtag.bsr_capture_in);  end
            1:       begin len = 32;   cap = 64'h1000_0001;             end
            2:       begin len = UW;   cap = 64'(jtag.user_capture_in); end
            default: begin len = 1;    cap = 64'd0;                     end
        endcase
        stream = (128'(din) << len) | 128'(cap);
        upd    = 64'(stream >> n) & ((64'd1 << len) - 64'd1);
        tick(1, 0);
        tick(0, 0);
        if (n > 0) begin
            tick(0, 0);
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(stream[i]);
                tick(0, din[i]);
            end
            exp_q.push_back(stream[n]);
        end
        tick(1, 0);
        tick(1, 0);
        if (kind == 0) m_bsr_upd  = upd[BSRL-1:0];
        if (kind == 2) m_user_upd = upd[UW-1:0];
        tick(0, 0);
        $display("DR scan: ir 0x%0h kind %0d bits %0d din 0x%0h capture 0x%0h update 0x%0h",
                 m_ir, kind, n, din, cap, upd);
    endtask

    initial begin : monitor
        forever begin
            @(negedge TCK);
            if (jtag.tdo_en && !ignore_tdo) begin
                if (exp_q.size() == 0) begin
                    check("tdo_unexpected_shift", 64'(jtag.tdo_en), 64'd0);
                end else begin
                    bit e;
                    e = exp_q.pop_front();
                    check("tdo", 64'(jtag.TDO), 64'(e));
                end
            end
        end
    end

    initial begin : stim
        logic [IRW-1:0] ops [6];
        logic [63:0]    d;
        int             kind;
        nxt0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
        nxt1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
        jtag.TMS             = 1'b1;
        jtag.TDI             = 1'b0;
        jtag.bsr_capture_in  = '0;
        jtag.user_capture_in = '0;
        model_reset();

        #2 TRST = 1'b0;
        #10;
        check("rst_tap_state", 64'(jtag.tap_state), 64'hF);
        check("rst_bsr_update_out", 64'(jtag.bsr_update_out), 64'd0);
        check("rst_user_update_out", 64'(jtag.user_update_out), 64'd0);
        check("rst_user_update_stb", 64'(jtag.user_update_stb), 64'd0);
        check("rst_bsr_mode", 64'(jtag.bsr_mode), 64'd0);
        check("rst_tdo_en", 64'(jtag.tdo_en), 64'd0);
        @(posedge TCK);
        #1 TRST = 1'b1;

        for (int i = 0; i < 5; i++) tick(1, 0);
        tick(0, 0);
        dr_scan(32, {$urandom, $urandom});

        ir_scan(IRW'(4'hF));
        dr_scan(20, {$urandom, $urandom});

        ir_scan(IRW'(2));
        jtag.bsr_capture_in = 14'h2A5A;
        dr_scan(14, 64'h1234);
        check("sample_update", 64'(jtag.bsr_update_out), 64'h1234);

        ir_scan(IRW'(0));
        for (int i = 0; i < 5; i++) tick(1, 0);
        check("extest_tlr_bsr_mode", 64'(jtag.bsr_mode), 64'd0);
        check("extest_tlr_hold", 64'(jtag.bsr_update_out), 64'h1234);
        tick(0, 0);

        ir_scan(IRW'(8));
        jtag.user_capture_in = 8'hC3;
        dr_scan(8, 64'h5A);
        check("user_update", 64'(jtag.user_update_out), USER_EN ? 64'h5A : 64'h0);

        ir_scan(IRW'(2));
        jtag.bsr_capture_in = 14'($urandom);
        dr_scan(0, 64'd0);

        ops = '{IRW'(0), IRW'(1), IRW'(2), IRW'(8), IRW'(4'hF), IRW'(0)};
        for (int t = 0; t < 24; t++) begin
            ops[5]               = IRW'($urandom_range(0, 15));
            jtag.bsr_capture_in  = 14'($urandom);
            jtag.user_capture_in = 8'($urandom);
            ir_scan(ops[$urandom_range(0, 5)]);
            dr_scan($urandom_range(0, 40), {$urandom, $urandom});
        end

        // TRST in the middle of a USER shift: abort, no update, no strobe.
        ir_scan(IRW'(8));
        jtag.user_capture_in = 8'($urandom);
        d    = {$urandom, $urandom};
        kind = dr_kind(m_ir);
        tick(1, 0); tick(0, 0); tick(0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(kind == 2 ? jtag.user_capture_in[i] : (i == 0 ? 1'b0 : d[i-1]));
            tick(0, d[i]);
        end
        TRST = 1'b0;
        #1;
        check("trst_tap_state", 64'(jtag.tap_state), 64'hF);
        check("trst_user_update_out", 64'(jtag.user_update_out), 64'd0);
        check("trst_user_update_stb", 64'(jtag.user_update_stb), 64'd0);
        check("trst_bsr_update_out", 64'(jtag.bsr_update_out), 64'd0);
        check("trst_tdo_en", 64'(jtag.tdo_en), 64'd0);
        model_reset();
        @(posedge TCK);
        #1 TRST = 1'b1;
        $display("TRST abort during USER shift");
        tick(1, 0);

        walk       = 1'b1;
        ignore_tdo = 1'b1;
        for (int i = 0; i < 200; i++) tick(1'($urandom), 1'($urandom));
        for (int i = 0; i < 5; i++) tick(1, 0);
        $display("Random TMS walk ended in state 0x%0h", jtag.tap_state);
        TRST = 1'b0;
        #2 TRST = 1'b1;
        model_reset();
        walk       = 1'b0;
        ignore_tdo = 1'b0;
        tick(0, 0);
        dr_scan(32, {$urandom, $urandom});

        tick(0, 0);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_tap_gen.md
JTAG_TAP_GEN -- requirements
Module: jtag_tap_gen

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4: instruction register length, minimum 2.
REQ-002 SHALL have parameter BSR_LEN, default 14: boundary-scan cell count.
REQ-003 SHALL have parameter USER_WIDTH, default 8: user data register length.
REQ-004 SHALL have parameter IDCODE_VAL, default 32'h1000_0001: 32-bit ID value, bit 0 fixed at 1.
REQ-005 SHALL have port TCK, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-006 SHALL have port TRST, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port TMS, input, 1 bit: TAP mode select.
REQ-008 SHALL have port TDI, input, 1 bit: serial data in.
REQ-009 SHALL have port TDO, output, 1 bit: serial data out.
REQ-010 SHALL have port tdo_en, output, 1 bit: high only in Shift-DR or Shift-IR.
REQ-011 SHALL have port tap_state, output, 4 bits: current TAP state encoding.
REQ-012 SHALL have port bsr_capture_in, input, BSR_LEN bits: system/pin values sampled at Capture-DR.
REQ-013 SHALL have port bsr_update_out, output, BSR_LEN bits: BSR update latch.
REQ-014 SHALL have port bsr_mode, output, 1 bit: high while the EXTEST opcode is the active instruction.
REQ-015 SHALL have port user_capture_in, input, USER_WIDTH bits: USER register capture value.
REQ-016 SHALL have port user_update_out, output, USER_WIDTH bits: USER register update latch.
REQ-017 SHALL have port user_update_stb, output, 1 bit: one-TCK pulse after a USER update.

Function
REQ-018 SHALL implement the 16-state IEEE 1149.1 TAP FSM, with transitions on TMS sampled at the TCK rising edge.
REQ-019 SHALL reach Test-Logic-Reset (TLR) after 5 consecutive TMS=1 cycles, from any state.
REQ-020 SHALL define opcodes: EXTEST = 0, IDCODE = 1, SAMPLE/PRELOAD = 2, USER = 8 (truncated to IR_WIDTH), BYPASS = all ones; any other opcode SHALL behave as BYPASS.
REQ-021 In Capture-IR, the IR shift stage SHALL load ...0001 (LSB first: 1, 0, 0, ...).
REQ-022 In Shift-IR, the IR shift stage SHALL shift right with TDI entering the MSB; the active IR SHALL change only in Update-IR.
REQ-023 SHALL select the data register from the active IR: BSR for EXTEST/SAMPLE, the 32-bit IDCODE register, the USER register, or the 1-bit BYPASS register.
REQ-024 In Capture-DR, the selected register SHALL load its source: bsr_capture_in, IDCODE_VAL, user_capture_in, or 0 for BYPASS.
REQ-025 In Shift-DR, only the selected register SHALL shift right, TDI into MSB; unselected registers SHALL hold.
REQ-026 TDO SHALL be combinational: the LSB of the IR stage in Shift-IR, the LSB of the selected DR in Shift-DR, else 0.
REQ-027 In Update-DR, bsr_update_out SHALL load the BSR shift stage for EXTEST/SAMPLE, and user_update_out SHALL load the USER shift stage for USER.
REQ-028 user_update_stb SHALL be high for exactly the cycle after Update-DR under USER.
REQ-029 Exit1 followed by Update with no Shift states in between SHALL still perform the update using the captured value.
REQ-030 TMS=1 mid-shift SHALL exit to Exit1 without a further shift on that edge.

Reset
REQ-031 TRST low SHALL asynchronously force TLR, active IR = IDCODE, all shift stages 0, bsr_update_out 0, user_update_out 0, user_update_stb 0, bsr_mode 0.
REQ-032 Entering TLR via TMS SHALL apply the same reset values synchronously, except the BSR and USER update latches, which SHALL hold their values.
REQ-033 TRST asserted mid-shift SHALL abort the shift; no update SHALL occur.

Configuration
REQ-034 With JTAG_USER_REG_EN defined, the USER register, user_update_out and user_update_stb SHALL be functional.
REQ-035 Without JTAG_USER_REG_EN, the USER opcode SHALL decode as BYPASS, user_update_out SHALL be tied to 0, user_update_stb SHALL be tied to 0, and no USER flops SHALL exist.

Verification
REQ-036 TRST low, then TMS=1 x5 -> tap_state=TLR; an IDCODE DR scan of 32 bits gives TDO LSB-first = 32'h1000_0001.
REQ-037 IR scan: TDI shifts in 4'hF -> first IR bits out on TDO are 1, 0, 0, 0; a following DR scan shows BYPASS with a 1-cycle delay TDI->TDO.
REQ-038 IR=SAMPLE, bsr_capture_in=14'h2A5A, DR scan shifting in 14'h1234 -> TDO gives 14'h2A5A; after Update-DR, bsr_update_out=14'h1234 and bsr_mode=0.
REQ-039 IR=EXTEST -> bsr_mode=1 from the cycle after Update-IR; TMS=1 x5 -> bsr_mode=0 and bsr_update_out unchanged.
REQ-040 IR=USER, user_capture_in=8'hC3, shift in 8'h5A -> TDO gives 8'hC3; user_update_out=8'h5A; user_update_stb pulses once. Without the macro, the same sequence gives BYPASS behaviour.
REQ-041 TRST pulsed after 3 bits of a USER shift -> tap_state=TLR immediately; user_update_out=0; no user_update_stb.
